// File: rtl/hazard_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl_pkg
//   Shared types, constants and the per-source hazard compare used by the
//   F/D/E stall controller and its mult/div busy counter.
//   Contents:
//     GPR_W         width of a general purpose register index
//     TUSE_NONE     Tuse encoding meaning "this source is not read"
//     *_LAT_DEF     default mult/div busy latencies and counter width
//     src_req_t     one D-stage source operand (index + Tuse)
//     wr_t          one in-flight writer (destination + Tnew)
//     src_hazard()  does a source have to wait for a writer
// -----------------------------------------------------------------------------
package hazard_stall_ctrl_pkg;

  localparam int          GPR_W        = 5;
  localparam int          T_W          = 2;
  localparam int          NUM_SRC      = 2;     // rs, rt
  localparam logic [1:0]  TUSE_NONE    = 2'd3;
  localparam int          MULT_LAT_DEF = 5;
  localparam int          DIV_LAT_DEF  = 10;
  localparam int          CNT_W_DEF    = 4;

  typedef logic [GPR_W-1:0] gpr_t;

  typedef struct packed {
    gpr_t           addr;
    logic [T_W-1:0] tuse;
  } src_req_t;

  typedef struct packed {
    gpr_t           wa;
    logic [T_W-1:0] tnew;
  } wr_t;

  // A source waits when the writer targets the same non-zero register and its
  // result is forwardable later than the source needs it. TUSE_NONE is the
  // largest 2-bit value, so it can never be strictly below any tnew.
  function automatic logic src_hazard(input src_req_t s, input wr_t w);
    return (s.addr != '0) && (s.addr == w.wa) && (s.tuse < w.tnew);
  endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl_if
//   Bundles the pipeline-side view of the stall controller.
//   master : the pipeline (drives D/E/M stage info, receives pause/flush)
//   slave  : the stall controller
//   Signals:
//     D_rs_addr/D_rt_addr, D_tuse_rs/D_tuse_rt  D-stage sources and Tuse
//     D_is_md                                   D touches HI/LO or mult/div
//     E_wa/E_tnew, M_wa/M_tnew                  in-flight writers
//     E_md_start/E_md_div                       mult/div issue from E
//     F_pause, D_pause, E_flush                 stall controls
//     md_busy                                   mult/div unit busy
// -----------------------------------------------------------------------------
interface hazard_stall_ctrl_if;
  import hazard_stall_ctrl_pkg::*;

  gpr_t       D_rs_addr;
  gpr_t       D_rt_addr;
  logic [1:0] D_tuse_rs;
  logic [1:0] D_tuse_rt;
  logic       D_is_md;
  gpr_t       E_wa;
  logic [1:0] E_tnew;
  gpr_t       M_wa;
  logic [1:0] M_tnew;
  logic       E_md_start;
  logic       E_md_div;
  logic       F_pause;
  logic       D_pause;
  logic       E_flush;
  logic       md_busy;

  modport master (
    output D_rs_addr, D_rt_addr, D_tuse_rs, D_tuse_rt, D_is_md,
    output E_wa, E_tnew, M_wa, M_tnew, E_md_start, E_md_div,
    input  F_pause, D_pause, E_flush, md_busy
  );

  modport slave (
    input  D_rs_addr, D_rt_addr, D_tuse_rs, D_tuse_rt, D_is_md,
    input  E_wa, E_tnew, M_wa, M_tnew, E_md_start, E_md_div,
    output F_pause, D_pause, E_flush, md_busy
  );
endinterface

// File: rtl/hazard_stall_ctrl_md_busy_counter.sv
// -----------------------------------------------------------------------------
// md_busy_counter
//   Tracks how many cycles the multi-cycle mult/div unit remains busy.
//   Ports:
//     clk        rising-edge clock
//     reset      synchronous, active-high; clears the count
//     start_i    E holds a mult/div this cycle
//     div_i      qualifies start_i: 1 = div/divu, 0 = mult/multu
//     md_busy_o  count != 0, or a start is being presented right now
// -----------------------------------------------------------------------------
module md_busy_counter #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic div_i,
  output logic md_busy_o
);

  logic [CNT_W-1:0] count_q, count_d;

  // A start seen while already counting is dropped: the unit is single-issue
  // and the stall logic keeps a dependent op in D until the count drains.
  always_comb begin
    count_d = '0;
    if (count_q != '0)
      count_d = count_q - CNT_W'(1);
    else if (start_i)
      count_d = div_i ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // Start is folded in combinationally so a dependent mfhi/mflo sitting in D
  // stalls in the very cycle the mult/div issues.
  assign md_busy_o = (count_q != '0) || start_i;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//   Produces pause/bubble controls for the F/D/E pipeline registers. A stall
//   freezes F and D and loads a bubble into E; E->M->W always drains, so no
//   pause is generated for those registers.
//   Ports:
//     clk    rising-edge clock
//     reset  synchronous, active-high
//     bus    hazard_stall_ctrl_if.slave (stage info in, pause/flush/busy out)
//   Stall sources:
//     - rs/rt read-after-write against the E and M writers (Tuse < Tnew)
//     - D instruction using HI/LO or mult/div while the unit is busy
// -----------------------------------------------------------------------------
module hazard_stall_ctrl
  import hazard_stall_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  hazard_stall_ctrl_if.slave bus
);

  src_req_t [NUM_SRC-1:0] src;
  wr_t                    wr_e, wr_m;
  logic     [NUM_SRC-1:0] hz_src;
  logic                   md_busy;
  logic                   md_stall;
  logic                   stall;

  assign src[0] = '{addr: bus.D_rs_addr, tuse: bus.D_tuse_rs};
  assign src[1] = '{addr: bus.D_rt_addr, tuse: bus.D_tuse_rt};
  assign wr_e   = '{wa: bus.E_wa, tnew: bus.E_tnew};
  assign wr_m   = '{wa: bus.M_wa, tnew: bus.M_tnew};

  // Each source is checked independently against both in-flight writers.
  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign hz_src[g] = src_hazard(src[g], wr_e) | src_hazard(src[g], wr_m);
  end

  md_busy_counter #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_cnt (
    .clk       (clk),
    .reset     (reset),
    .start_i   (bus.E_md_start),
    .div_i     (bus.E_md_div),
    .md_busy_o (md_busy)
  );

  assign md_stall = bus.D_is_md && md_busy;
  assign stall    = (|hz_src) || md_stall;

  // Zero-latency: the same cycle's D contents decide the freeze.
  assign bus.F_pause = stall;
  assign bus.D_pause = stall;
  assign bus.E_flush = stall;
  assign bus.md_busy = md_busy;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//   Directed scenarios followed by random stage traffic. The driver computes
//   expected outputs from a cycle-number model of the mult/div unit and the
//   hazard rules, queues them, and a negedge monitor compares them.
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;
  import hazard_stall_ctrl_pkg::*;

  localparam int MLAT = 5;
  localparam int DLAT = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_stall_ctrl_if bif ();

  hazard_stall_ctrl #(.MULT_LAT(MLAT), .DIV_LAT(DLAT), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  typedef struct packed {
    logic [4:0] rs, rt;
    logic [1:0] trs, trt;
    logic       is_md;
    logic [4:0] ewa;
    logic [1:0] etn;
    logic [4:0] mwa;
    logic [1:0] mtn;
    logic       st, dv, rst;
  } stim_t;

  typedef struct {
    logic  stall;
    logic  busy;
    string tag;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Model state: the mult/div unit is busy in every cycle strictly before
  // busy_until (plus any cycle presenting a start).
  int cyc        = 0;
  int busy_until = 0;

  function automatic logic needs_wait(input logic [4:0] a, input logic [1:0] tu,
                                      input stim_t s);
    int u;
    u = int'(tu);
    if (a == 5'd0) return 1'b0;
    if (a == s.ewa && u < int'(s.etn)) return 1'b1;
    if (a == s.mwa && u < int'(s.mtn)) return 1'b1;
    return 1'b0;
  endfunction

  task automatic drive(input stim_t s, input string tag);
    exp_t e;
    logic busy_now;
    @(posedge clk); #1;
    reset          = s.rst;
    bif.D_rs_addr  = s.rs;
    bif.D_rt_addr  = s.rt;
    bif.D_tuse_rs  = s.trs;
    bif.D_tuse_rt  = s.trt;
    bif.D_is_md    = s.is_md;
    bif.E_wa       = s.ewa;
    bif.E_tnew     = s.etn;
    bif.M_wa       = s.mwa;
    bif.M_tnew     = s.mtn;
    bif.E_md_start = s.st;
    bif.E_md_div   = s.dv;
    busy_now = (cyc < busy_until) || s.st;
    e.busy   = busy_now;
    e.stall  = needs_wait(s.rs, s.trs, s) || needs_wait(s.rt, s.trt, s) ||
               (s.is_md && busy_now);
    e.tag    = tag;
    q.push_back(e);
    if (s.rst)
      busy_until = cyc + 1;
    else if (s.st && !(cyc < busy_until))
      busy_until = cyc + 1 + (s.dv ? DLAT : MLAT);
    cyc++;
  endtask

  task automatic chk(input string name, input string tag, input logic act,
                     input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s [%s] cyc-ish t=%0t got %b expected %b", name, tag, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("F_pause", e.tag, bif.F_pause, e.stall);
      chk("D_pause", e.tag, bif.D_pause, e.stall);
      chk("E_flush", e.tag, bif.E_flush, e.stall);
      chk("md_busy", e.tag, bif.md_busy, e.busy);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    reset = 1'b1;
    {bif.D_rs_addr, bif.D_rt_addr, bif.D_tuse_rs, bif.D_tuse_rt, bif.D_is_md} = '0;
    {bif.E_wa, bif.E_tnew, bif.M_wa, bif.M_tnew, bif.E_md_start, bif.E_md_div} = '0;

    // 1: start during reset must not load; everything idle afterwards
    s = '0; s.rst = 1'b1; s.st = 1'b1; s.dv = 1'b1;
    drive(s, "rst_start");
    s = '0; drive(s, "post_rst");
    drive(s, "post_rst2");

    // 2: rs RAW against E then M
    s = '0; s.rs = 5'd8; s.trs = 2'd0; s.trt = TUSE_NONE; s.ewa = 5'd8; s.etn = 2'd2;
    drive(s, "rs_E_tnew2");
    s.etn = 2'd1;
    drive(s, "rs_E_tnew1");
    s.ewa = 5'd0; s.etn = 2'd0; s.mwa = 5'd8; s.mtn = 2'd0;
    drive(s, "rs_M_ready");
    s.mtn = 2'd1;
    drive(s, "rs_M_tnew1");
    s.trs = TUSE_NONE; s.ewa = 5'd8; s.etn = 2'd2;
    drive(s, "rs_unused");

    // 3: $0 never hazards
    s = '0; s.rt = 5'd0; s.trt = 2'd0; s.ewa = 5'd0; s.etn = 2'd2;
    drive(s, "rt_zero");
    s = '0; s.rt = 5'd9; s.trt = 2'd1; s.ewa = 5'd9; s.etn = 2'd2;
    drive(s, "rt_E");

    // 4: mult start with dependent md op in D
    s = '0; s.st = 1'b1; s.dv = 1'b0; s.is_md = 1'b1;
    drive(s, "mult_t0");
    s.st = 1'b0;
    for (int i = 1; i <= 7; i++) drive(s, $sformatf("mult_t%0d", i));

    // 5: div start, second start mid-count is ignored
    s = '0; s.st = 1'b1; s.dv = 1'b1;
    drive(s, "div_t0");
    s.st = 1'b0; s.is_md = 1'b1;
    drive(s, "div_t1");
    drive(s, "div_t2");
    s.st = 1'b1;
    drive(s, "div_t3_restart");
    s.st = 1'b0;
    for (int i = 4; i <= 12; i++) drive(s, $sformatf("div_t%0d", i));

    // 6: reset mid-divide
    s = '0; s.st = 1'b1; s.dv = 1'b1;
    drive(s, "rdiv_t0");
    s.st = 1'b0;
    for (int i = 1; i <= 3; i++) drive(s, $sformatf("rdiv_t%0d", i));
    s.rst = 1'b1;
    drive(s, "rdiv_t4_rst");
    s.rst = 1'b0; s.is_md = 1'b1;
    drive(s, "rdiv_t5");
    drive(s, "rdiv_t6");

    // random traffic over a small register window to hit matches often
    for (int n = 0; n < 600; n++) begin
      s       = '0;
      s.rs    = 5'($urandom_range(0, 3));
      s.rt    = 5'($urandom_range(0, 3));
      s.trs   = 2'($urandom_range(0, 3));
      s.trt   = 2'($urandom_range(0, 3));
      s.is_md = ($urandom_range(0, 2) == 0);
      s.ewa   = 5'($urandom_range(0, 3));
      s.etn   = 2'($urandom_range(0, 2));
      s.mwa   = 5'($urandom_range(0, 3));
      s.mtn   = 2'($urandom_range(0, 1));
      s.st    = ($urandom_range(0, 4) == 0);
      s.dv    = 1'($urandom_range(0, 1));
      s.rst   = ($urandom_range(0, 49) == 0);
      drive(s, "rand");
    end

    s = '0;
    drive(s, "tail");
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    @(posedge clk); #1;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected entries left, required 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
